// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load still in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic                  i_ex_memread,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  output logic                  o_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign o_hazard  = i_ex_memread && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait freeze, branch flush,
// load-use stall, memory-timeout error FSM and saturating performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  mem_err,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic             w_load_use;
  logic             w_freeze;
  logic             w_branch_hon;
  logic             w_pc_en;
  logic             w_exmem_en;
  stage_ctrl_t      w_ifid;
  stage_ctrl_t      w_idex;
  stage_ctrl_t      w_memwb;

  load_use_detect u_load_use_detect (
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .i_ex_memread (ex_memread),
    .i_ex_rd      (ex_rd),
    .o_hazard     (w_load_use)
  );

  // In RUN a freeze needs an outstanding request; once in MEM_WAIT only ready releases it.
  assign w_freeze = (r_state == ST_RUN) ? (dmem_req && !dmem_ready) : !dmem_ready;

  always_comb begin
    w_pc_en      = 1'b0;
    w_exmem_en   = 1'b0;
    w_ifid       = '0;
    w_idex       = '0;
    w_memwb      = '0;
    w_branch_hon = 1'b0;
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    if (reset) begin
      w_ifid.flush  = 1'b1;
      w_idex.flush  = 1'b1;
      w_memwb.flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (w_freeze) begin
            w_memwb.flush = 1'b1;
            if (r_state == ST_RUN) begin
              w_state_nxt = ST_MEM_WAIT;
              w_wait_nxt  = 8'd1;
            end else begin
              w_wait_nxt = r_wait_cnt + 8'd1;
              if (w_wait_nxt == LP_TIMEOUT) w_state_nxt = ST_ERROR;
            end
          end else begin
            w_state_nxt = ST_RUN;
            w_wait_nxt  = '0;
            w_pc_en     = 1'b1;
            w_ifid.en   = 1'b1;
            w_idex.en   = 1'b1;
            w_exmem_en  = 1'b1;
            w_memwb.en  = 1'b1;
            if (ex_branch_taken) begin
              w_ifid.flush = 1'b1;
              w_idex.flush = 1'b1;
              w_branch_hon = 1'b1;
            end else if (w_load_use) begin
              w_pc_en      = 1'b0;
              w_ifid.en    = 1'b0;
              w_idex.flush = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_state_nxt == ST_ERROR) r_mem_err <= 1'b1;
      if ((r_state != ST_ERROR) && !w_pc_en && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_branch_hon && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign pc_en        = w_pc_en;
  assign ifid_en      = w_ifid.en;
  assign idex_en      = w_idex.en;
  assign exmem_en     = w_exmem_en;
  assign memwb_en     = w_memwb.en;
  assign ifid_flush   = w_ifid.flush;
  assign idex_flush   = w_idex.flush;
  assign memwb_flush  = w_memwb.flush;
  assign mem_err      = r_mem_err;
  assign halted       = (r_state == ST_ERROR);
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl with a short timeout and narrow counters.
module tb_pipeline_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken;
  logic       dmem_req, dmem_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, memwb_flush;
  logic       mem_err, halted;
  logic [3:0] stall_cycles, flush_count;

  typedef struct {
    string      name;
    logic [4:0] en;
    logic [2:0] fl;
    logic       err;
    logic       halt;
    logic [3:0] st;
    logic [3:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pipeline_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .mem_err         (mem_err),
    .halted          (halted),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  // Monitor: outputs settle combinationally, so compare at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".en"},    {3'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {3'b0, e.en});
      chk({e.name, ".flush"}, {5'b0, ifid_flush, idex_flush, memwb_flush},       {5'b0, e.fl});
      chk({e.name, ".err"},   {6'b0, mem_err, halted},                          {6'b0, e.err, e.halt});
      chk({e.name, ".stall"}, {4'b0, stall_cycles},                             {4'b0, e.st});
      chk({e.name, ".fcnt"},  {4'b0, flush_count},                              {4'b0, e.fc});
    end
  end

  task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic br,
                      input logic req, input logic rdy,
                      input logic [4:0] e_en, input logic [2:0] e_fl,
                      input logic e_err, input logic e_halt,
                      input logic [3:0] e_st, input logic [3:0] e_fc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ex_memread = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; ex_branch_taken = br;
    dmem_req = req; dmem_ready = rdy;
    e.name = nm; e.en = e_en; e.fl = e_fl; e.err = e_err; e.halt = e_halt;
    e.st = e_st; e.fc = e_fc;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    repeat (2) @(posedge clk);

    //   rst mr rd     rs1    rs2    u1 u2 br rq rdy  en        fl      er h  st     fc
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b00000, 3'b111, 0, 0, 4'd0, 4'd0, "reset");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd0, 4'd0, "idle");
    step(0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 5'b00111, 3'b010, 0, 0, 4'd0, 4'd0, "lu_rs2");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd1, 4'd0, "after_lu");
    step(0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd1, 4'd0, "rd_zero");
    step(0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, 5'b11111, 3'b110, 0, 0, 4'd1, 4'd0, "br_lu");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd1, 4'd1, "after_br");
    step(0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0, 5'b00111, 3'b010, 0, 0, 4'd1, 4'd1, "lu_rs1");
    step(0, 1, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd2, 4'd1, "no_use");
    // freeze with a pending branch, ready on the 4th (= MEM_TIMEOUT-th) frozen cycle
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 5'b00000, 3'b001, 0, 0, 4'd2, 4'd1, "frz1");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 5'b00000, 3'b001, 0, 0, 4'd3, 4'd1, "frz2");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 5'b00000, 3'b001, 0, 0, 4'd4, 4'd1, "frz3");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 5'b11111, 3'b110, 0, 0, 4'd5, 4'd1, "release");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd5, 4'd2, "after_rel");
    // timeout: never ready
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'b00000, 3'b001, 0, 0, 4'd5, 4'd2, "to1");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'b00000, 3'b001, 0, 0, 4'd6, 4'd2, "to2");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'b00000, 3'b001, 0, 0, 4'd7, 4'd2, "to3");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'b00000, 3'b001, 0, 0, 4'd8, 4'd2, "to4");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 5'b00000, 3'b000, 1, 1, 4'd9, 4'd2, "error");
    step(0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 1, 1, 5'b00000, 3'b000, 1, 1, 4'd9, 4'd2, "err_hold");
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b00000, 3'b111, 1, 1, 4'd9, 4'd2, "err_reset");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd0, 4'd0, "post_reset");
    // 20 load-use stalls on a 4-bit counter
    for (int i = 0; i < 20; i++)
      step(0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 5'b00111, 3'b010, 0, 0,
           (i > 15) ? 4'd15 : 4'(i), 4'd0, "sat");
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11111, 3'b000, 0, 0, 4'd15, 4'd0, "sat_end");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
